// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Definitions shared by the sequential divider and the multiplier sequencer.
//   - state_t : FSM encodings. The multiplier sequencer decodes the same values,
//               so do not renumber them.
//   - cnt_width(): width of the step counter for a given operand width.
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_OUTPUT  = 2'd3
    } state_t;

    // One extra bit of headroom so the counter can hold WIDTH-1 for any WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring division iteration, purely combinational.
//   {rem,quo} is shifted left by one. The divisor is then subtracted from the
//   widened partial remainder. If the difference is not negative it is kept and
//   a 1 enters the quotient. Otherwise the shifted remainder is kept and a 0
//   enters the quotient.
// Ports
//   rem_in   in  WIDTH  partial remainder (always < divisor)
//   quo_in   in  WIDTH  partial quotient / remaining dividend bits
//   divisor  in  WIDTH  divisor magnitude
//   rem_out  out WIDTH  updated partial remainder
//   quo_out  out WIDTH  updated partial quotient
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_div_ext;
    logic [WIDTH-1:0] w_quo_sh;
    logic             w_ge;

    assign w_rem_sh  = {rem_in, quo_in[WIDTH-1]};
    assign w_div_ext = {1'b0, divisor};
    assign w_quo_sh  = {quo_in[WIDTH-2:0], 1'b0};

    // A non-negative WIDTH+1 bit trial difference is the same as an unsigned
    // compare of the shifted remainder against the divisor.
    assign w_ge = (w_rem_sh >= w_div_ext);

    // When w_ge holds, the difference is below the divisor, so its top bit is
    // zero and truncating it to WIDTH bits loses nothing.
    always_comb begin
        rem_out = w_rem_sh[WIDTH-1:0];
        quo_out = w_quo_sh;
        if (w_ge) begin
            rem_out = WIDTH'(w_rem_sh - w_div_ext);
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative signed integer divider. It takes one restoring step per cycle and
//   finishes in WIDTH+1 cycles after an accepted start. It uses the same
//   start/busy/done handshake as the Booth multiplier.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting for start. Operand magnitudes and signs are latched here.
//   ST_RUNNING | one restoring step per cycle, WIDTH steps in total
//   ST_OUTPUT  | done pulse. q/r hold the sign-corrected result.
//
//   Rounding truncates toward zero, and r takes the sign of x.
//   When y==0 the result is q = all ones and r = x, with div_by_zero set.
//   In this case the state goes IDLE->OUTPUT directly.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   x, y         in   WIDTH  dividend / divisor, two's complement
//   start        in   1      request, sampled only in ST_IDLE
//   is_signed    in   1      only with DIV_UNSIGNED_MODE_EN. 0 means unsigned operands.
//   q, r         out  WIDTH  quotient / remainder, held until the next accepted start
//   busy         out  1      high in ST_RUNNING
//   done         out  1      one-cycle pulse in ST_OUTPUT
//   div_by_zero  out  1      set together with done when y==0
//
// Build option: define DIV_UNSIGNED_MODE_EN to add the is_signed port.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             start,
`ifdef DIV_UNSIGNED_MODE_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_q;
    logic             r_sign_r;

    logic             w_signed;
    logic             w_neg_x;
    logic             w_neg_y;
    logic [WIDTH-1:0] w_abs_x;
    logic [WIDTH-1:0] w_abs_y;
    logic             w_y_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

`ifdef DIV_UNSIGNED_MODE_EN
    assign w_signed = is_signed;
`else
    assign w_signed = 1'b1;
`endif

    assign w_neg_x  = w_signed & x[WIDTH-1];
    assign w_neg_y  = w_signed & y[WIDTH-1];

    // The magnitudes are read as unsigned WIDTH-bit values. The two's
    // complement negation of -2^(WIDTH-1) gives the bit pattern of +2^(WIDTH-1),
    // so the most negative operand is still exact.
    assign w_abs_x  = w_neg_x ? -x : x;
    assign w_abs_y  = w_neg_y ? -y : y;
    assign w_y_zero = (y == '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_div),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_y_zero ? ST_OUTPUT : ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The result registers are loaded on the edge that enters ST_OUTPUT, so
    // q/r are already valid in the cycle where done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_abs_x;
                        r_div    <= w_abs_y;
                        r_sign_q <= w_neg_x ^ w_neg_y;
                        r_sign_r <= w_neg_x;
                        if (w_y_zero) begin
                            q           <= '1;
                            r           <= x;
                            div_by_zero <= 1'b1;
                        end else begin
                            q           <= '0;
                            r           <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ST_RUNNING: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        q <= r_sign_q ? -w_quo_nxt : w_quo_nxt;
                        r <= r_sign_r ? -w_rem_nxt : w_rem_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         start;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_by_zero;
`ifdef DIV_UNSIGNED_MODE_EN
    logic         is_signed;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .start       (start),
`ifdef DIV_UNSIGNED_MODE_EN
        .is_signed   (is_signed),
`endif
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one divide and checks the latency, the busy length, the result,
    // the single-cycle done pulse and that the result is held afterwards.
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input bit edbz);
        int lat;
        int busy_n;
        bit got_done;
        lat      = 0;
        busy_n   = 0;
        got_done = 0;
        @(negedge clk);
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!got_done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (lat == 1 && !edbz) check({tag, ".dbz_clr"}, div_by_zero, 0);
            if (done) got_done = 1;
        end
        check({tag, ".lat"}, lat, edbz ? 1 : W + 1);
        check({tag, ".busy_n"}, busy_n, edbz ? 0 : W);
        check({tag, ".q"}, q, eq);
        check({tag, ".r"}, r, er);
        check({tag, ".dbz"}, div_by_zero, edbz);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".q_hold"}, q, eq);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        logic [W-1:0] q1;
        logic [W-1:0] q2;
        logic [W-1:0] r2;
        int ia;
        int ib;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
`ifdef DIV_UNSIGNED_MODE_EN
        is_signed = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.q", q, 0);
        check("rst.r", r, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.dbz", div_by_zero, 0);
        rst_n = 1'b1;

        do_div("t1", 16'd100, 16'd7, 16'd14, 16'd2, 0);
        do_div("t2a", -16'sd100, 16'd7, -16'sd14, -16'sd2, 0);
        do_div("t2b", 16'd100, -16'sd7, -16'sd14, 16'd2, 0);
        do_div("t2c", -16'sd100, -16'sd7, 16'd14, -16'sd2, 0);
        do_div("t3a", 16'd7, 16'd0, 16'hFFFF, 16'd7, 1);
        do_div("t3b", 16'd10, 16'd3, 16'd3, 16'd1, 0);
        do_div("t3c", 16'h8000, 16'd0, 16'hFFFF, 16'h8000, 1);
        do_div("t4a", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 0);
        do_div("t4b", 16'h8000, 16'd1, 16'h8000, 16'd0, 0);
        do_div("t4c", 16'h7FFF, 16'h8000, 16'd0, 16'h7FFF, 0);
        do_div("t4d", 16'd3, 16'd5, 16'd0, 16'd3, 0);

        // start held high while x/y keep changing. Only the operands present
        // at the accepting IDLE edges (cycle 0 and cycle 18) may be used.
        done_cnt    = 0;
        first_done  = 0;
        second_done = 0;
        q1 = '0;
        q2 = '0;
        r2 = '0;
        @(negedge clk);
        x     = 16'd100;
        y     = 16'd7;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin first_done = k; q1 = q; end
                if (done_cnt == 2) begin second_done = k; q2 = q; r2 = r; end
            end
            if (k == 18) begin
                x = 16'd50;
                y = 16'd5;
            end else begin
                x = 16'(k * 37 + 1000);
                y = 16'(k + 3);
            end
            if (k == 36) start = 1'b0;
        end
        check("t5.done_cnt", done_cnt, 2);
        check("t5.first", first_done, 17);
        check("t5.second", second_done, 35);
        check("t5.q1", q1, 14);
        check("t5.q2", q2, 10);
        check("t5.r2", r2, 0);
        repeat (W + 3) @(negedge clk);
        check("t5.idle", busy, 0);

        // Reset asserted during a divide aborts it at once.
        @(negedge clk);
        x     = 16'd1000;
        y     = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("t6.busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6.q", q, 0);
        check("t6.r", r, 0);
        check("t6.busy", busy, 0);
        check("t6.done", done, 0);
        check("t6.dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_div("t6post", 16'd50, 16'd5, 16'd10, 16'd0, 0);

`ifdef DIV_UNSIGNED_MODE_EN
        is_signed = 1'b0;
        do_div("u1", 16'hFFFF, 16'd2, 16'h7FFF, 16'd1, 0);
        do_div("u2", 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 0);
        do_div("u3", 16'hFFF0, 16'd0, 16'hFFFF, 16'hFFF0, 1);
        do_div("u4", 16'd60000, 16'd7, 16'd8571, 16'd3, 0);
        is_signed = 1'b1;
`endif

        // Small random sweep against the language's signed / and %.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 0) rb = 16'($urandom_range(1, 20));
            if (rb == 16'd0) rb = 16'd3;
            if (ra == 16'h8000 && rb == 16'hFFFF) rb = 16'd3;
            ia = int'($signed(ra));
            ib = int'($signed(rb));
            do_div($sformatf("rnd%0d", i), ra, rb, 16'(ia / ib), 16'(ia % ib), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
